// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int PC_STEP     = 4;

  // RV32I major opcodes seen by decode
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, valid/ready hand-off to execute,
// branch redirect on consume, sticky error on a misaligned next PC.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic [6:0]             opcode,
  output logic [2:0]             funct3,
  output logic [6:0]             funct7,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_offset,
  output logic                   fetch_err
);

  fetch_state_t          state;
  logic [PC_WIDTH-1:0]   pc;
  logic [PC_WIDTH-1:0]   next_pc;
  logic                  consume;

  assign imem_addr = pc;
  assign consume   = instr_valid & instr_ready;
  assign next_pc   = instr_pc + (branch_taken ? branch_offset : PC_WIDTH'(PC_STEP));

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Handshake outputs are registered so they stay low for the whole reset window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= REQ;
      pc             <= RESET_PC;
      imem_req_valid <= 1'b0;
      instr_valid    <= 1'b0;
      instr          <= '0;
      instr_pc       <= '0;
      fetch_err      <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (imem_req_valid && imem_req_ready) begin
            imem_req_valid <= 1'b0;
            state          <= WAIT;
          end else begin
            imem_req_valid <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            instr       <= imem_rsp_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (consume) begin
            instr_valid <= 1'b0;
            if (next_pc[1:0] != 2'b00) begin
              fetch_err <= 1'b1;
              state     <= ERR;
            end else begin
              pc             <= next_pc;
              imem_req_valid <= 1'b1;
              state          <= REQ;
            end
          end
        end
        default: begin
          imem_req_valid <= 1'b0;
          instr_valid    <= 1'b0;
          fetch_err      <= 1'b1;
        end
      endcase
    end
  end

endmodule
